// File: rtl/sar_operand_search_pkg.sv
// Shared definitions for the successive-approximation operand search:
// operand width, FSM state encoding and the offset-binary encode/decode.
package sar_operand_search_pkg;

  localparam int WIDTH = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_PROBE = 2'd1;
  localparam state_t ST_DONE  = 2'd2;
  localparam state_t ST_ERR   = 2'd3;

  // Offset-binary <-> two's complement is a flip of the sign bit, both ways.
  function automatic logic [WIDTH-1:0] offset_flip(input logic [WIDTH-1:0] v);
    offset_flip = v ^ {1'b1, {(WIDTH-1){1'b0}}};
  endfunction

endpackage

// File: rtl/sar_operand_search_trial_gen.sv
// Trial-code register for the search: holds the offset-binary code and the
// bit index under test, and computes the keep/clear + next-bit update.
module sar_operand_search_trial_gen
  import sar_operand_search_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_keep,
  output logic [WIDTH-1:0] o_code,
  output logic [WIDTH-1:0] o_code_next,
  output logic             o_last
);

  localparam int               IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

  logic [WIDTH-1:0] r_code;
  logic [IDX_W-1:0] r_idx;

  // Decide the bit under test, then arm the next lower bit as the new trial.
  always_comb begin
    o_code_next        = r_code;
    o_code_next[r_idx] = i_keep;
    if (r_idx != '0) begin
      o_code_next[r_idx - 1'b1] = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_code <= '0;
      r_idx  <= '0;
    end else if (i_load) begin
      r_code <= {1'b1, {(WIDTH-1){1'b0}}};
      r_idx  <= IDX_TOP;
    end else if (i_step) begin
      r_code <= o_code_next;
      if (r_idx != '0) begin
        r_idx <= r_idx - 1'b1;
      end
    end
  end

  assign o_code = r_code;
  assign o_last = (r_idx == '0);

endmodule

// File: rtl/sar_operand_search.sv
// Successive-approximation search that recovers the hidden A operand of an
// external signed comparator by driving trial values on out_B.
module sar_operand_search
  import sar_operand_search_pkg::*;
(
  input  logic             inp_clk,
  input  logic             inp_rst,
  input  logic             inp_start,
  input  logic             inp_AequalB,
  input  logic             inp_AgreaterB,
  input  logic             inp_BgreaterA,
  output logic [WIDTH-1:0] out_B,
  output logic             out_busy,
  output logic             out_done,
  output logic [WIDTH-1:0] out_result,
  output logic             out_err,
  output state_t           out_dbg_state
);

  // Handshake: a one-cycle inp_start is accepted in IDLE/DONE/ERR and ignored
  // in PROBE; out_done then stays high with out_result valid until the next
  // accepted start or reset. The comparator flags must settle within a cycle.

  state_t           r_state;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] w_code;
  logic [WIDTH-1:0] w_code_next;
  logic             w_last;
  logic             w_onehot;
  logic             w_load;
  logic             w_step;

  assign w_onehot = $onehot({inp_AequalB, inp_AgreaterB, inp_BgreaterA});
  assign w_load   = inp_start && (r_state != ST_PROBE);
  assign w_step   = (r_state == ST_PROBE) && w_onehot && !inp_AequalB;

  sar_operand_search_trial_gen u_trial_gen (
    .i_clk       (inp_clk),
    .i_rst       (inp_rst),
    .i_load      (w_load),
    .i_step      (w_step),
    .i_keep      (inp_AgreaterB),
    .o_code      (w_code),
    .o_code_next (w_code_next),
    .o_last      (w_last)
  );

  always_ff @(posedge inp_clk) begin
    if (inp_rst) begin
      r_state  <= ST_IDLE;
      r_result <= '0;
    end else begin
      case (r_state)
        ST_PROBE: begin
          if (!w_onehot) begin
            r_state <= ST_ERR;
          end else if (inp_AequalB) begin
            r_result <= out_B;
            r_state  <= ST_DONE;
          end else if (w_last) begin
            r_result <= offset_flip(w_code_next);
            r_state  <= ST_DONE;
          end
        end
        default: begin
          if (inp_start) begin
            r_state <= ST_PROBE;
          end
        end
      endcase
    end
  end

  assign out_B         = offset_flip(w_code);
  assign out_busy      = (r_state == ST_PROBE);
  assign out_done      = (r_state == ST_DONE);
  assign out_err       = (r_state == ST_ERR);
  assign out_result    = r_result;
  assign out_dbg_state = r_state;

endmodule

// File: tb/tb_sar_operand_search.sv
// Self-checking bench for sar_operand_search with a behavioural signed
// comparator, a probe/result scoreboard and flag-fault injection.
module tb_sar_operand_search;
  import sar_operand_search_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             eq, gt, lt;
  logic [WIDTH-1:0] b;
  logic             busy, done, err;
  logic [WIDTH-1:0] result;
  state_t           dbg_state;

  int               tb_a;
  logic             force_en;
  logic [2:0]       force_val;

  int n_cmp = 0;
  int n_bad = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] res_q[$];

  // clock / reset
  always #5 clk = ~clk;

  // behavioural signed comparator with a fault override
  always_comb begin
    if (force_en) begin
      {eq, gt, lt} = force_val;
    end else begin
      eq = (int'($signed(b)) == tb_a);
      gt = (tb_a > int'($signed(b)));
      lt = (int'($signed(b)) > tb_a);
    end
  end

  sar_operand_search dut (
    .inp_clk       (clk),
    .inp_rst       (rst),
    .inp_start     (start),
    .inp_AequalB   (eq),
    .inp_AgreaterB (gt),
    .inp_BgreaterA (lt),
    .out_B         (b),
    .out_busy      (busy),
    .out_done      (done),
    .out_result    (result),
    .out_err       (err),
    .out_dbg_state (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference binary search on signed integers: probe 0, then move by
  // halving steps; pushes up to lim probe values, returns probe count/result.
  task automatic push_expect(input int a, input int lim, output int n, output int res);
    int p;
    int step;
    logic [31:0] pv;
    p    = 0;
    step = 1 << (WIDTH - 2);
    n    = 0;
    res  = 0;
    for (int k = 0; k < WIDTH; k++) begin
      if (n < lim) begin
        pv = p;
        exp_q.push_back(pv[WIDTH-1:0]);
      end
      n++;
      if (a == p) begin
        res = p;
        break;
      end
      if (k == WIDTH - 1) begin
        res = (a > p) ? p : p - 1;
      end else begin
        if (a > p) p = p + step;
        else       p = p - step;
        step = step >> 1;
      end
    end
  endtask

  // monitor: every busy cycle must present the next expected probe
  always @(negedge clk) begin
    check("busy_done_excl", busy & done, 0);
    if (busy) begin
      check("probe_avail", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("probe_B", b, exp_q.pop_front());
    end
  end

  task automatic run_search(input int a);
    int n, res, cyc;
    logic [31:0] rv;
    logic [WIDTH-1:0] exp_res;
    tb_a = a;
    push_expect(a, WIDTH, n, res);
    rv = res;
    res_q.push_back(rv[WIDTH-1:0]);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("busy_first", busy, 1);
    check("done_low_in_probe", done, 0);
    check("err_clear", err, 0);
    cyc = 1;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("done_cycle", cyc, n + 1);
    exp_res = res_q.size() != 0 ? res_q.pop_front() : '0;
    check("result", result, exp_res);
    check("probes_left", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    check("done_hold", done, 1);
    check("result_hold", result, exp_res);
  endtask

  task automatic run_err(input int a, input logic [2:0] fv);
    int n, res;
    logic [31:0] pv;
    tb_a = a;
    push_expect(a, 2, n, res);
    pv = (a > 0) ? (1 << (WIDTH - 2)) : -(1 << (WIDTH - 2));
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk) begin
      force_en  = 1'b1;
      force_val = fv;
    end
    @(negedge clk);
    check("err_set", err, 1);
    check("err_busy", busy, 0);
    check("err_done", done, 0);
    check("err_B_hold", b, pv[WIDTH-1:0]);
    check("err_probes_left", exp_q.size(), 0);
    exp_q.delete();
    force_en = 1'b0;
    @(negedge clk);
    check("err_hold", err, 1);
    check("err_state", dbg_state, ST_ERR);
  endtask

  task automatic run_reset_mid_probe();
    int n, res;
    tb_a = 5;
    push_expect(5, 3, n, res);
    @(negedge clk) start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_err", err, 0);
    check("mrst_result", result, 0);
    check("mrst_B", b, {1'b1, {(WIDTH-1){1'b0}}});
    check("mrst_state", dbg_state, ST_IDLE);
    check("mrst_probes_left", exp_q.size(), 0);
    exp_q.delete();
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("mrst_idle_stays", dbg_state, ST_IDLE);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    force_en  = 1'b0;
    force_val = 3'b000;
    tb_a      = 0;
    repeat (2) @(negedge clk);
    check("rst_B", b, {1'b1, {(WIDTH-1){1'b0}}});
    check("rst_result", result, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_state", dbg_state, ST_IDLE);
    rst = 1'b0;
    @(negedge clk);

    run_search(0);
    run_search(5);
    run_search(-8);
    run_search(7);
    run_search(-3);
    run_err(3, 3'b000);
    run_search(3);
    run_err(-5, 3'b110);
    run_search(-5);
    for (int i = 0; i < 8; i++) begin
      run_search(int'($urandom_range(0, 15)) - 8);
    end
    run_reset_mid_probe();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
